// File: rtl/accum_tile_drain_pkg.sv
// Shared definitions for the accumulator tile drain path.
//   complex_t     : one accumulator element, {re, im}, fp32 each (64 bits)
//   tile_set_t    : one capture, [tile][row][col] of complex_t
//   drain_state_e : drain FSM states
package accum_tile_drain_pkg;

  localparam int NUM_TILES      = 4;
  localparam int TILE_DIM       = 4;
  localparam int ELEM_W         = 64;
  localparam int LINE_W         = 512;
  localparam int ELEMS_PER_LINE = LINE_W / ELEM_W;
  localparam int LINES          = NUM_TILES * TILE_DIM * TILE_DIM * ELEM_W / LINE_W;
  localparam int IDX_W          = $clog2(LINES);

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  typedef complex_t [0:NUM_TILES-1][0:TILE_DIM-1][0:TILE_DIM-1] tile_set_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/accum_tile_drain_tile_line_mux.sv
// Combinational selection of one output line from a full tile set.
//   i_buf  : 64-element capture buffer [tile][row][col]
//   i_idx  : line index k (0..7)
//   o_line : line k; tile k>>1, rows 2*(k&1) and 2*(k&1)+1,
//            element (r,c) in slot (r&1)*4+c
module tile_line_mux
  import accum_tile_drain_pkg::*;
(
  input  tile_set_t          i_buf,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [LINE_W-1:0]  o_line
);

  logic [2:0] w_slot;

  always_comb begin
    o_line = '0;
    w_slot = '0;
    for (int s = 0; s < ELEMS_PER_LINE; s++) begin
      w_slot = 3'(s);
      // slot bit 2 picks the odd row of the pair, slot bits 1:0 are the column
      o_line[ELEM_W*s +: ELEM_W] = i_buf[i_idx[2:1]][{i_idx[0], w_slot[2]}][w_slot[1:0]];
    end
  end

endmodule

// File: rtl/accum_tile_drain.sv
// Drains captured accumulator tile sets as eight 512-bit lines over a
// valid/ready handshake, with one pending buffer behind the active one.
//   clk, reset (async, active-low)
//   tile_in/tile_valid    : capture input from the accumulator
//   line_data/line_idx/line_valid/line_ready : output line handshake
//   tile_done             : pulse after the last line of a capture
//   busy                  : FSM is draining
//   overflow              : sticky, a capture was dropped
//
// state | meaning
// IDLE  | active buffer empty, waiting for tile_valid
// DRAIN | presenting line r_idx of the active buffer
module accum_tile_drain
  import accum_tile_drain_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  tile_set_t          tile_in,
  input  logic               tile_valid,
  output logic [LINE_W-1:0]  line_data,
  output logic [IDX_W-1:0]   line_idx,
  output logic               line_valid,
  input  logic               line_ready,
  output logic               tile_done,
  output logic               busy,
  output logic               overflow
);

  drain_state_e      r_state;
  tile_set_t         r_active;
  tile_set_t         r_pending;
  logic              r_pend_full;
  logic [IDX_W-1:0]  r_idx;
  logic              r_line_valid;
  logic              r_tile_done;
  logic              r_overflow;

  logic              w_hs;
  logic              w_last;
  logic [LINE_W-1:0] w_line;

  assign w_hs   = r_line_valid & line_ready;
  assign w_last = w_hs & (r_idx == IDX_W'(LINES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_full  <= 1'b0;
      r_idx        <= '0;
      r_line_valid <= 1'b0;
      r_tile_done  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tile_valid) begin
            r_active     <= tile_in;
            r_idx        <= '0;
            r_line_valid <= 1'b1;
            r_state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last) begin
            r_tile_done <= 1'b1;
            r_idx       <= '0;
            if (r_pend_full) begin
              // promote; a same-cycle capture refills pending, so nothing is lost
              r_active <= r_pending;
              if (tile_valid) begin
                r_pending <= tile_in;
              end else begin
                r_pend_full <= 1'b0;
              end
            end else if (tile_valid) begin
              r_active <= tile_in;
            end else begin
              r_line_valid <= 1'b0;
              r_state      <= IDLE;
            end
          end else begin
            if (w_hs) begin
              r_idx <= r_idx + 1'b1;
            end
            if (tile_valid) begin
              if (!r_pend_full) begin
                r_pending   <= tile_in;
                r_pend_full <= 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_line_valid <= 1'b0;
        end
      endcase
    end
  end

  tile_line_mux u_line_mux (
    .i_buf  (r_active),
    .i_idx  (r_idx),
    .o_line (w_line)
  );

  // r_active resets to zero, so line_data reads zero out of reset
  assign line_data  = w_line;
  assign line_idx   = r_idx;
  assign line_valid = r_line_valid;
  assign tile_done  = r_tile_done;
  assign busy       = (r_state == DRAIN);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_accum_tile_drain.sv
// Directed bench for accum_tile_drain. Each capture pushes its eight expected
// lines onto a scoreboard; a negedge monitor compares every presented line
// against the queue head and pops on handshake, and checks tile_done against
// the last popped line.
module tb_accum_tile_drain;
  import accum_tile_drain_pkg::*;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  tile_set_t         tile_in;
  logic              tile_valid;
  logic [LINE_W-1:0] line_data;
  logic [IDX_W-1:0]  line_idx;
  logic              line_valid;
  logic              line_ready;
  logic              tile_done;
  logic              busy;
  logic              overflow;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   hs_cnt, hs_first, hs_last, done_cnt, ncyc;
  bit   exp_done;

  accum_tile_drain dut (
    .clk        (clk),
    .reset      (reset),
    .tile_in    (tile_in),
    .tile_valid (tile_valid),
    .line_data  (line_data),
    .line_idx   (line_idx),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .tile_done  (tile_done),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tile_set_t make_tiles(input logic [31:0] base);
    tile_set_t t;
    for (int ti = 0; ti < 4; ti++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          t[ti][r][c].re = base + 32'(ti * 16 + r * 4 + c);
          t[ti][r][c].im = ~t[ti][r][c].re;
        end
    return t;
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input tile_set_t t, input int k);
    logic [LINE_W-1:0] l;
    int tl;
    int s;
    l  = '0;
    tl = k / 2;
    for (int r = 2 * (k % 2); r < 2 * (k % 2) + 2; r++)
      for (int c = 0; c < 4; c++) begin
        s = (r % 2) * 4 + c;
        l[64*s +: 64] = {t[tl][r][c].re, t[tl][r][c].im};
      end
    return l;
  endfunction

  task automatic push_capture(input tile_set_t t);
    exp_t e;
    for (int k = 0; k < LINES; k++) begin
      e.idx  = IDX_W'(k);
      e.data = exp_line(t, k);
      sb.push_back(e);
    end
  endtask

  // drive tile_valid for the cycle starting now (called at posedge+1)
  task automatic capture_now(input tile_set_t t, input bit emitted);
    tile_in    = t;
    tile_valid = 1'b1;
    if (emitted) push_capture(t);
    @(posedge clk); #1;
    tile_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [IDX_W-1:0] v, input int maxc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (line_valid && line_idx == v) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, LINE_W'(ok), LINE_W'(1));
  endtask

  task automatic wait_drained(input int maxc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !line_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, LINE_W'(ok), LINE_W'(1));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic clear_counts();
    hs_cnt   = 0;
    hs_first = 0;
    hs_last  = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    clear_counts();
  endtask

  initial begin
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset      = 1'b0;
    tile_valid = 1'b0;
    line_ready = 1'b0;
    tile_in    = '0;
    exp_done   = 1'b0;
    ncyc       = 0;
    clear_counts();

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          exp_done = 1'b0;
        end else begin
          chk("tile_done", LINE_W'(tile_done), LINE_W'(exp_done));
          if (tile_done) done_cnt++;
          exp_done = 1'b0;
          if (line_valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_line", LINE_W'(line_valid), LINE_W'(0));
            end else begin
              chk("line_idx", LINE_W'(line_idx), LINE_W'(sb[0].idx));
              chk("line_data", line_data, sb[0].data);
              if (line_ready) begin
                exp_done = (sb[0].idx == IDX_W'(LINES - 1));
                void'(sb.pop_front());
                hs_cnt++;
                if (hs_cnt == 1) hs_first = ncyc;
                hs_last = ncyc;
              end
            end
          end
        end
        ncyc++;
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_line_valid", LINE_W'(line_valid), LINE_W'(0));
    chk("rst_line_idx",   LINE_W'(line_idx),   LINE_W'(0));
    chk("rst_line_data",  line_data,           LINE_W'(0));
    chk("rst_tile_done",  LINE_W'(tile_done),  LINE_W'(0));
    chk("rst_busy",       LINE_W'(busy),       LINE_W'(0));
    chk("rst_overflow",   LINE_W'(overflow),   LINE_W'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: single capture, ready held high
    clear_counts();
    line_ready = 1'b1;
    @(posedge clk); #1;
    capture_now(make_tiles(32'h0), 1'b1);
    chk("t1_first_line", LINE_W'({line_valid, line_idx}), LINE_W'(4'b1000));
    wait_idx(3'd3, 10, "t1_wait_idx3");
    chk("t1_line3_slot5", LINE_W'(line_data[64*5 +: 64]), LINE_W'({32'd29, ~32'd29}));
    wait_drained(40, "t1_drain_timeout");
    chk("t1_handshakes", LINE_W'(hs_cnt), LINE_W'(8));
    chk("t1_back_to_back", LINE_W'(hs_last - hs_first), LINE_W'(7));
    chk("t1_done_cnt", LINE_W'(done_cnt), LINE_W'(1));

    // 2: backpressure with ready pattern 1,0,0,1
    clear_counts();
    line_ready = 1'b0;
    capture_now(make_tiles(32'h100), 1'b1);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      line_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    line_ready = 1'b1;
    wait_drained(40, "t2_drain_timeout");
    chk("t2_handshakes", LINE_W'(hs_cnt), LINE_W'(8));
    chk("t2_done_cnt", LINE_W'(done_cnt), LINE_W'(1));

    // 3: second capture during drain goes to pending, no bubble between sets
    clear_counts();
    line_ready = 1'b1;
    capture_now(make_tiles(32'h200), 1'b1);
    wait_idx(3'd4, 10, "t3_wait_idx4");
    capture_now(make_tiles(32'h300), 1'b1);
    wait_drained(60, "t3_drain_timeout");
    chk("t3_handshakes", LINE_W'(hs_cnt), LINE_W'(16));
    chk("t3_back_to_back", LINE_W'(hs_last - hs_first), LINE_W'(15));
    chk("t3_done_cnt", LINE_W'(done_cnt), LINE_W'(2));
    chk("t3_overflow", LINE_W'(overflow), LINE_W'(0));

    // 4: third capture with pending full is dropped, overflow sticks
    clear_counts();
    line_ready = 1'b0;
    capture_now(make_tiles(32'h400), 1'b1);
    @(posedge clk); #1;
    capture_now(make_tiles(32'h500), 1'b1);
    chk("t4_no_overflow_yet", LINE_W'(overflow), LINE_W'(0));
    @(posedge clk); #1;
    capture_now(make_tiles(32'h600), 1'b0);
    chk("t4_overflow_set", LINE_W'(overflow), LINE_W'(1));
    chk("t4_busy", LINE_W'(busy), LINE_W'(1));
    line_ready = 1'b1;
    wait_drained(60, "t4_drain_timeout");
    chk("t4_handshakes", LINE_W'(hs_cnt), LINE_W'(16));
    chk("t4_done_cnt", LINE_W'(done_cnt), LINE_W'(2));
    chk("t4_overflow_sticky", LINE_W'(overflow), LINE_W'(1));

    // 5: capture coincides with last handshake, pending empty
    pulse_reset();
    chk("t5_overflow_cleared", LINE_W'(overflow), LINE_W'(0));
    line_ready = 1'b1;
    capture_now(make_tiles(32'h700), 1'b1);
    wait_idx(3'd7, 10, "t5_wait_idx7");
    capture_now(make_tiles(32'h800), 1'b1);
    chk("t5_restart", LINE_W'({line_valid, line_idx}), LINE_W'(4'b1000));
    chk("t5_busy", LINE_W'(busy), LINE_W'(1));
    chk("t5_done_pulse", LINE_W'(tile_done), LINE_W'(1));
    wait_drained(40, "t5_drain_timeout");
    chk("t5_handshakes", LINE_W'(hs_cnt), LINE_W'(16));
    chk("t5_back_to_back", LINE_W'(hs_last - hs_first), LINE_W'(15));
    chk("t5_done_cnt", LINE_W'(done_cnt), LINE_W'(2));
    chk("t5_overflow", LINE_W'(overflow), LINE_W'(0));

    // 6: reset in the middle of a drain
    clear_counts();
    line_ready = 1'b1;
    capture_now(make_tiles(32'h900), 1'b1);
    wait_idx(3'd4, 10, "t6_wait_idx4");
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("t6_line_valid", LINE_W'(line_valid), LINE_W'(0));
    chk("t6_line_idx",   LINE_W'(line_idx),   LINE_W'(0));
    chk("t6_line_data",  line_data,           LINE_W'(0));
    chk("t6_busy",       LINE_W'(busy),       LINE_W'(0));
    chk("t6_tile_done",  LINE_W'(tile_done),  LINE_W'(0));
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t6_idle_valid", LINE_W'(line_valid), LINE_W'(0));
      chk("t6_idle_busy",  LINE_W'(busy),       LINE_W'(0));
    end
    chk("t6_no_done", LINE_W'(done_cnt), LINE_W'(0));
    capture_now(make_tiles(32'hA00), 1'b1);
    wait_drained(40, "t6_drain_timeout");
    chk("t6_handshakes", LINE_W'(hs_cnt), LINE_W'(8));
    chk("t6_done_cnt", LINE_W'(done_cnt), LINE_W'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
